fifo_sync: RTL and testbench
============================

Name: fifo_sync

Overview:
Single-clock, parametrised FIFO for same-domain buffering, such as CPU-to-peripheral command queues and audio/video sample staging.
- Adds features the dual-clock Gray-pointer FIFO lacks: occupancy count, programmable almost-full/almost-empty thresholds, first-word-fall-through (FWFT) or registered-read mode, synchronous flush, and overflow/underflow strobes.
- No pointer synchronisers; occupancy is exact every cycle.

Parameters:
DSIZE, 8, data word width in bits (>=1)
ASIZE, 4, address width; DEPTH = 2**ASIZE words (ASIZE>=1)
FWFT, 1, 1 = head word visible on RDATA whenever !REMPTY; 0 = RDATA registered, loaded on pop
AF_LEVEL, DEPTH-2, WAFULL asserted when LEVEL >= AF_LEVEL (legal range 1..DEPTH)
AE_LEVEL, 2, RAEMPTY asserted when LEVEL <= AE_LEVEL (legal range 0..DEPTH-1)

Ports:
CLK  in  1  single clock, rising edge
RST_N  in  1  reset; synchronous, active-low
FLUSH  in  1  synchronous empty request
WDATA  in  DSIZE  write data
WINC  in  1  push request
WFULL  out  1  FIFO holds DEPTH words
WAFULL  out  1  LEVEL >= AF_LEVEL
OVERFLOW  out  1  one-cycle strobe: push attempted while full
RDATA  out  DSIZE  read data
RINC  in  1  pop request
REMPTY  out  1  FIFO holds 0 words
RAEMPTY  out  1  LEVEL <= AE_LEVEL
UNDERFLOW  out  1  one-cycle strobe: pop attempted while empty
LEVEL  out  ASIZE+1  current occupancy, 0..DEPTH

Behaviour:
Reset:
- Sampled only at a CLK edge with RST_N=0.
- Clears both pointers and sets LEVEL=0, WFULL=0, WAFULL=0, REMPTY=1, RAEMPTY=1, OVERFLOW=0, UNDERFLOW=0.
- FWFT=0: RDATA=0.
- Memory contents are not cleared.
- Reset asserted mid-operation discards all data, with the same result as at power-up.

Push and pop acceptance:
- Push accepted iff WINC && !WFULL. Pop accepted iff RINC && !REMPTY.
- Flags are evaluated against the pre-edge state, so:
  - A simultaneous WINC+RINC while full accepts only the pop.
  - A simultaneous WINC+RINC while empty accepts only the push.
- Accepted push: mem[wptr] <= WDATA, then wptr+1.
- Accepted pop: rptr+1.
- Pointers are ASIZE bits and wrap modulo DEPTH.

Occupancy and flags:
- LEVEL_next = LEVEL + push_acc - pop_acc. When both are accepted, LEVEL is unchanged.
- All flags are registered from LEVEL_next, so they are consistent with LEVEL in the same cycle:
  - WFULL = (LEVEL==DEPTH)
  - REMPTY = (LEVEL==0)
  - WAFULL = (LEVEL>=AF_LEVEL)
  - RAEMPTY = (LEVEL<=AE_LEVEL)
- Push-to-visibility latency: 1 cycle. REMPTY deasserts on the edge that writes the first word.

Read modes:
- FWFT=1:
  - RDATA = mem[rptr], an asynchronous read.
  - Valid whenever !REMPTY; don't-care while REMPTY.
  - An accepted pop advances RDATA to the next word after the edge.
- FWFT=0:
  - An accepted pop loads RDATA <= mem[rptr] at the edge, so data is valid the cycle after RINC.
  - RDATA holds its value otherwise, including across flush.

Strobes:
- OVERFLOW <= WINC && WFULL.
- UNDERFLOW <= RINC && REMPTY.
- Each is high for exactly one cycle per offending cycle. Neither changes FIFO state.

FLUSH:
- Takes priority over WINC/RINC in the same cycle.
- Next state: both pointers 0, LEVEL=0, flags at their reset values, strobes 0.
- FWFT=0: RDATA is unaffected.

Arithmetic:
- LEVEL is ASIZE+1 bits, so DEPTH is representable.
- Threshold comparisons are unsigned and ASIZE+1 bits wide.

Decomposition:
- No shared package is needed. DEPTH is a localparam (1<<ASIZE).
- Threshold legality is checked at elaboration; an illegal value is a fatal error in simulation.
- One sub-module: fifo_sync_mem, a DEPTH x DSIZE RAM with a synchronous write port and an asynchronous read port, inferable as distributed RAM.
- The FWFT=0 output register lives in fifo_sync, not in the RAM.

Test Plan:
1. Fill and drain (ASIZE=2, FWFT=1): push 1,2,3,4 -> LEVEL 1..4, WFULL high after 4th edge; pop 4 times -> RDATA 1,2,3,4 in order, REMPTY high after last pop.
2. Boundary races (ASIZE=2):
   - Full, then WINC+RINC same cycle -> only pop accepted, LEVEL=3, no OVERFLOW.
   - Empty, then WINC+RINC -> LEVEL=1, UNDERFLOW=1 for one cycle.
3. Wrap and thresholds (ASIZE=3, AF_LEVEL=6, AE_LEVEL=2):
   - Stream 20 words with interleaved pops -> output equals input order.
   - WAFULL tracks LEVEL>=6 each cycle; RAEMPTY tracks LEVEL<=2 each cycle.
4. Registered mode (FWFT=0): push 0xA5,0x5A; RINC at cycle t -> RDATA=0xA5 at t+1; RINC at t+1 -> RDATA=0x5A at t+2; RDATA holds with RINC=0.
5. Flush/reset mid-stream: LEVEL=5, assert FLUSH with WINC+RINC -> next cycle LEVEL=0, REMPTY=1, no write stored. Repeat with RST_N=0 instead -> same result plus OVERFLOW/UNDERFLOW=0.
6. Error strobes: full FIFO with WINC held 3 cycles -> OVERFLOW high 3 cycles, LEVEL stays DEPTH, contents unchanged on drain.

Source files
------------

// File: rtl/fifo_sync_mem.sv
// DEPTH x DSIZE storage for fifo_sync: synchronous write, asynchronous read,
// shaped so it maps onto distributed RAM.
module fifo_sync_mem #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             CLK,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);
  localparam int DEPTH = 1 << ASIZE;

  logic [DSIZE-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO with exact occupancy, almost-full/empty thresholds,
// FWFT or registered read, synchronous flush and overflow/underflow strobes.
module fifo_sync #(
  parameter int DSIZE    = 8,
  parameter int ASIZE    = 4,
  parameter bit FWFT     = 1'b1,
  parameter int AF_LEVEL = (1 << ASIZE) - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             FLUSH,
  input  logic [DSIZE-1:0] WDATA,
  input  logic             WINC,
  output logic             WFULL,
  output logic             WAFULL,
  output logic             OVERFLOW,
  output logic [DSIZE-1:0] RDATA,
  input  logic             RINC,
  output logic             REMPTY,
  output logic             RAEMPTY,
  output logic             UNDERFLOW,
  output logic [ASIZE:0]   LEVEL
);
  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] DEPTH_L = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] AF_TH   = (ASIZE+1)'(AF_LEVEL);
  localparam logic [ASIZE:0] AE_TH   = (ASIZE+1)'(AE_LEVEL);

  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $fatal(1, "fifo_sync: AF_LEVEL out of range 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $fatal(1, "fifo_sync: AE_LEVEL out of range 0..DEPTH-1");
  end

  logic [ASIZE-1:0] wptr, rptr;
  logic [ASIZE:0]   level_nxt;
  logic [DSIZE-1:0] head;
  logic             push_acc, pop_acc, wr_en;

  // Acceptance uses the registered flags, i.e. the pre-edge state.
  assign push_acc  = WINC && !WFULL;
  assign pop_acc   = RINC && !REMPTY;
  assign wr_en     = push_acc && RST_N && !FLUSH;
  assign level_nxt = LEVEL + (ASIZE+1)'(push_acc) - (ASIZE+1)'(pop_acc);

  fifo_sync_mem #(.DSIZE(DSIZE), .ASIZE(ASIZE)) u_mem (
    .CLK   (CLK),
    .we    (wr_en),
    .waddr (wptr),
    .wdata (WDATA),
    .raddr (rptr),
    .rdata (head)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N || FLUSH) begin
      wptr      <= '0;
      rptr      <= '0;
      LEVEL     <= '0;
      WFULL     <= 1'b0;
      REMPTY    <= 1'b1;
      WAFULL    <= 1'b0;
      RAEMPTY   <= 1'b1;
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      if (push_acc) wptr <= wptr + 1'b1;
      if (pop_acc)  rptr <= rptr + 1'b1;
      LEVEL     <= level_nxt;
      WFULL     <= (level_nxt == DEPTH_L);
      REMPTY    <= (level_nxt == '0);
      WAFULL    <= (level_nxt >= AF_TH);
      RAEMPTY   <= (level_nxt <= AE_TH);
      OVERFLOW  <= WINC && WFULL;
      UNDERFLOW <= RINC && REMPTY;
    end
  end

  if (FWFT) begin : g_fwft
    assign RDATA = head;
  end else begin : g_reg
    // Output register keeps its word across flush; only reset clears it.
    always_ff @(posedge CLK) begin
      if (!RST_N)                RDATA <= '0;
      else if (pop_acc && !FLUSH) RDATA <= head;
    end
  end
endmodule

// File: tb/tb_fifo_sync.sv
// Randomized bench for fifo_sync: two configurations share stimulus and are
// compared cycle by cycle against queue-based reference models.
module tb_fifo_sync;
  localparam int DW = 8;
  localparam int AA = 3, DA = 8, AFA = 6, AEA = 2;  // FWFT, custom thresholds
  localparam int AB = 2, DB = 4, AFB = 2, AEB = 2;  // registered read, defaults

  logic          CLK = 1'b0;
  logic          RST_N, FLUSH, WINC, RINC;
  logic [DW-1:0] WDATA;

  logic          a_wfull, a_wafull, a_ovf, a_rempty, a_raempty, a_unf;
  logic [DW-1:0] a_rdata;
  logic [AA:0]   a_level;
  logic          b_wfull, b_wafull, b_ovf, b_rempty, b_raempty, b_unf;
  logic [DW-1:0] b_rdata;
  logic [AB:0]   b_level;

  fifo_sync #(.DSIZE(DW), .ASIZE(AA), .FWFT(1'b1), .AF_LEVEL(AFA), .AE_LEVEL(AEA)) u_a (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH), .WDATA(WDATA), .WINC(WINC),
    .WFULL(a_wfull), .WAFULL(a_wafull), .OVERFLOW(a_ovf), .RDATA(a_rdata),
    .RINC(RINC), .REMPTY(a_rempty), .RAEMPTY(a_raempty), .UNDERFLOW(a_unf),
    .LEVEL(a_level)
  );

  fifo_sync #(.DSIZE(DW), .ASIZE(AB), .FWFT(1'b0)) u_b (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH), .WDATA(WDATA), .WINC(WINC),
    .WFULL(b_wfull), .WAFULL(b_wafull), .OVERFLOW(b_ovf), .RDATA(b_rdata),
    .RINC(RINC), .REMPTY(b_rempty), .RAEMPTY(b_raempty), .UNDERFLOW(b_unf),
    .LEVEL(b_level)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference state: queues hold FIFO contents, head at index 0.
  logic [DW-1:0] qa[$], qb[$];
  logic          ova, una, ovb, unb;
  logic [DW-1:0] rdb_m;

  task automatic model_edge();
    if (!RST_N || FLUSH) begin
      qa.delete(); qb.delete();
      ova = 0; una = 0; ovb = 0; unb = 0;
      if (!RST_N) rdb_m = '0;
    end else begin
      ova = WINC && (qa.size() == DA);
      una = RINC && (qa.size() == 0);
      ovb = WINC && (qb.size() == DB);
      unb = RINC && (qb.size() == 0);
      begin
        bit popa, pusha, popb, pushb;
        popa  = RINC && qa.size() > 0;
        pusha = WINC && qa.size() < DA;
        popb  = RINC && qb.size() > 0;
        pushb = WINC && qb.size() < DB;
        if (popa) void'(qa.pop_front());
        if (pusha) qa.push_back(WDATA);
        if (popb) begin rdb_m = qb[0]; void'(qb.pop_front()); end
        if (pushb) qb.push_back(WDATA);
      end
    end
  endtask

  task automatic check_all();
    int sa, sb;
    sa = qa.size(); sb = qb.size();
    chk("a_level",   32'(a_level),   32'(sa));
    chk("a_wfull",   32'(a_wfull),   32'(sa == DA));
    chk("a_rempty",  32'(a_rempty),  32'(sa == 0));
    chk("a_wafull",  32'(a_wafull),  32'(sa >= AFA));
    chk("a_raempty", 32'(a_raempty), 32'(sa <= AEA));
    chk("a_ovf",     32'(a_ovf),     32'(ova));
    chk("a_unf",     32'(a_unf),     32'(una));
    if (sa > 0) chk("a_rdata", 32'(a_rdata), 32'(qa[0]));
    chk("b_level",   32'(b_level),   32'(sb));
    chk("b_wfull",   32'(b_wfull),   32'(sb == DB));
    chk("b_rempty",  32'(b_rempty),  32'(sb == 0));
    chk("b_wafull",  32'(b_wafull),  32'(sb >= AFB));
    chk("b_raempty", 32'(b_raempty), 32'(sb <= AEB));
    chk("b_ovf",     32'(b_ovf),     32'(ovb));
    chk("b_unf",     32'(b_unf),     32'(unb));
    chk("b_rdata",   32'(b_rdata),   32'(rdb_m));
  endtask

  task automatic cycle(input logic rst_n, input logic flush, input logic winc,
                       input logic rinc, input logic [DW-1:0] wd);
    RST_N = rst_n; FLUSH = flush; WINC = winc; RINC = rinc; WDATA = wd;
    @(posedge CLK);
    model_edge();
    #1 check_all();
    @(negedge CLK);
  endtask

  // Push/pop percentages per phase: fill, drain, balanced, push-heavy, pop-heavy.
  int pw_tab[5] = '{90, 10, 50, 70, 30};
  int pr_tab[5] = '{10, 90, 50, 30, 70};

  initial begin
    qa.delete(); qb.delete();
    ova = 0; una = 0; ovb = 0; unb = 0; rdb_m = '0;
    RST_N = 0; FLUSH = 0; WINC = 0; RINC = 0; WDATA = '0;
    @(negedge CLK);
    cycle(0, 0, 0, 0, 8'h00);
    cycle(0, 0, 1, 1, 8'h33);

    // Directed: fill past full, race at full, drain past empty, race at empty.
    for (int i = 0; i < 10; i++) cycle(1, 0, 1, 0, 8'(i + 1));
    cycle(1, 0, 1, 1, 8'hEE);
    for (int i = 0; i < 10; i++) cycle(1, 0, 0, 1, 8'h00);
    cycle(1, 0, 1, 1, 8'h77);
    cycle(1, 0, 0, 1, 8'h00);

    // Registered-read hold: push two words, pop each, then idle.
    cycle(1, 0, 1, 0, 8'hA5);
    cycle(1, 0, 1, 0, 8'h5A);
    cycle(1, 0, 0, 1, 8'h00);
    cycle(1, 0, 0, 1, 8'h00);
    cycle(1, 0, 0, 0, 8'h00);
    cycle(1, 0, 0, 0, 8'h00);

    // Mid-stream flush then reset, each with WINC+RINC asserted.
    for (int i = 0; i < 5; i++) cycle(1, 0, 1, 0, 8'(8'h40 + i));
    cycle(1, 1, 1, 1, 8'hBB);
    cycle(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) cycle(1, 0, 1, 0, 8'(8'h50 + i));
    cycle(0, 0, 1, 1, 8'hCC);
    cycle(1, 0, 0, 0, 8'h00);

    // Randomized phases with occasional flush and reset.
    for (int p = 0; p < 40; p++) begin
      int ph;
      ph = $urandom_range(0, 4);
      for (int c = 0; c < 60; c++) begin
        logic rn, fl, wi, ri;
        rn = ($urandom_range(0, 299) != 0);
        fl = ($urandom_range(0, 79) == 0);
        wi = ($urandom_range(0, 99) < pw_tab[ph]);
        ri = ($urandom_range(0, 99) < pr_tab[ph]);
        cycle(rn, fl, wi, ri, 8'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
